// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states and frame constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  // Header is a 4-byte little-endian word count.
  localparam int unsigned HdrBytes     = 4;
  localparam int unsigned BytesPerWord = 4;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Little-endian byte assembler used by the program loader.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_clear       synchronous clear of shift register and byte counter
//   i_push        shift i_byte in this cycle
//   i_byte        incoming byte
//   o_word        assembled word including the byte currently being pushed
//   o_cnt         bytes already held for the word in progress
//   o_word_full   this push completes a word (o_word is then the full word)
module byte_to_word #(
  parameter int unsigned NBytes = 4,
  localparam int unsigned W = 8 * NBytes,
  localparam int unsigned CntW = $clog2(NBytes)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_push,
  input  logic [7:0]      i_byte,
  output logic [W-1:0]    o_word,
  output logic [CntW-1:0] o_cnt,
  output logic            o_word_full
);

  logic [W-1:0]    r_word;
  logic [CntW-1:0] r_cnt;
  logic            w_last;

  assign w_last      = (r_cnt == CntW'(NBytes - 1));
  // Newest byte enters at the top, so after NBytes pushes byte 0 sits in [7:0].
  assign o_word      = {i_byte, r_word[W-1:8]};
  assign o_cnt       = r_cnt;
  assign o_word_full = i_push && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_push) begin
      r_word <= o_word;
      r_cnt  <= w_last ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed program (word count, words, XOR checksum)
// and writes it into instruction memory, holding the core in reset until success.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid  byte stream from the receiver
//   o_rx_ready            byte accepted when i_rx_valid && o_rx_ready
//   o_imem_we/addr/wdata  one-cycle instruction RAM write (byte address, word-aligned)
//   o_core_rst            core reset request, low only after a successful load
//   o_done, o_error       sticky completion / abort flags
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_rst,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned MaxWords = 2 ** ADDR_W;
  localparam int unsigned IdleW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CntW     = $clog2(BytesPerWord);

  state_e            r_state, w_state_d;
  logic              r_rx_ready;
  logic              r_imem_we;
  logic [31:0]       r_imem_addr, r_imem_wdata;
  logic [ADDR_W:0]   r_count, r_word_idx, w_idx_inc;
  logic [7:0]        r_csum;
  logic [IdleW-1:0]  r_idle;

  logic              w_accept, w_push, w_word_full, w_hdr_last, w_hdr_bad;
  logic              w_timeout, w_idle_en;
  logic [31:0]       w_word;
  logic [CntW-1:0]   w_byte_cnt;

  assign w_accept   = i_rx_valid && r_rx_ready;
  // Checksum byte is compared, not assembled.
  assign w_push     = w_accept && ((r_state == StHdr) || (r_state == StData));
  assign w_hdr_last = w_push && (r_state == StHdr) && (w_byte_cnt == CntW'(HdrBytes - 1));
  assign w_hdr_bad  = (w_word == '0) || (w_word > 32'(MaxWords));
  assign w_timeout  = (r_idle == IdleW'(TIMEOUT_CYC));
  assign w_idle_en  = ((r_state == StHdr) && (w_byte_cnt != '0)) ||
                      (r_state == StData) || (r_state == StCsum);
  assign w_idx_inc  = r_word_idx + (ADDR_W + 1)'(1);

  byte_to_word #(
    .NBytes(BytesPerWord)
  ) u_byte_to_word (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (r_state == StIdle),
    .i_push     (w_push),
    .i_byte     (i_rx_data),
    .o_word     (w_word),
    .o_cnt      (w_byte_cnt),
    .o_word_full(w_word_full)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  w_state_d = StHdr;
      StHdr: begin
        if (w_timeout)       w_state_d = StErr;
        else if (w_hdr_last) w_state_d = w_hdr_bad ? StErr : StData;
      end
      StData: begin
        if (w_timeout)        w_state_d = StErr;
        else if (w_word_full) w_state_d = StWrite;
      end
      StWrite: w_state_d = (w_idx_inc == r_count) ? StCsum : StData;
      StCsum: begin
        if (w_timeout)     w_state_d = StErr;
        else if (w_accept) w_state_d = (i_rx_data == r_csum) ? StDone : StErr;
      end
      StDone:  w_state_d = StDone;
      StErr:   w_state_d = StErr;
      default: w_state_d = StErr;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_csum       <= '0;
      r_idle       <= '0;
    end else begin
      r_state    <= w_state_d;
      // Ready follows the state being entered, so it drops in WRITE and terminal states.
      r_rx_ready <= (w_state_d == StHdr) || (w_state_d == StData) || (w_state_d == StCsum);
      r_imem_we  <= (w_state_d == StWrite);
      if (w_state_d == StWrite) begin
        r_imem_addr  <= 32'(r_word_idx) << 2;
        r_imem_wdata <= w_word;
      end
      if (r_state == StWrite) r_word_idx <= w_idx_inc;
      if (w_push)     r_csum  <= r_csum ^ i_rx_data;
      if (w_hdr_last) r_count <= w_word[ADDR_W:0];
      if (w_accept)                     r_idle <= '0;
      else if (w_idle_en && !w_timeout) r_idle <= r_idle + IdleW'(1);
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_core_rst   = (r_state != StDone);
  assign o_done       = (r_state == StDone);
  assign o_error      = (r_state == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W = 10, TIMEOUT_CYC = 16).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, core_rst, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int we_cnt = 0;
  int ready_in_write = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  logic [7:0] stim [0:12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'h92};

  prog_loader #(
    .ADDR_W     (10),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_wdata(imem_wdata),
    .o_core_rst  (core_rst),
    .o_done      (done),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so negedge sees what the next posedge will.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) acc_cnt++;
      if (imem_we) begin
        we_cnt++;
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
        if (rx_ready) ready_in_write++;
      end
    end
  end

  task automatic clear_log();
    acc_cnt = 0;
    we_cnt = 0;
    ready_in_write = 0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    bit ok;
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!keep) rx_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_byte: byte %02h accepted=%0b want 1 within 40 cycles", b, ok);
    end
  endtask

  task automatic send_stream(input int n, input logic [7:0] last, input int gap, input bit keep);
    for (int i = 0; i < n; i++) begin
      send_byte((i == 12) ? last : stim[i], keep);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", rx_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b want 0", imem_we); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst: got %0b want 1", core_rst); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %0b want 0", error); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL hdr_ready: got %0b want 1", rx_ready); end
  endtask

  task automatic test_good_load();
    do_reset();
    send_stream(13, 8'h92, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL good_we_count: got %0d want 2", we_cnt); end
    if (wa_q.size() >= 2) begin
      total++; if (wa_q[0] !== 32'h0) begin bad++; $display("FAIL good_addr0: got %h want 0", wa_q[0]); end
      total++; if (wd_q[0] !== 32'h00000013) begin bad++; $display("FAIL good_data0: got %h want 00000013", wd_q[0]); end
      total++; if (wa_q[1] !== 32'h4) begin bad++; $display("FAIL good_addr1: got %h want 4", wa_q[1]); end
      total++; if (wd_q[1] !== 32'h00100093) begin bad++; $display("FAIL good_data1: got %h want 00100093", wd_q[1]); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL good_done: got %0b want 1", done); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL good_core_rst: got %0b want 0", core_rst); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL good_error: got %0b want 0", error); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL good_ready: got %0b want 0", rx_ready); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_stream(13, 8'h00, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL csum_we_count: got %0d want 2", we_cnt); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL csum_error: got %0b want 1", error); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL csum_done: got %0b want 0", done); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL csum_core_rst: got %0b want 1", core_rst); end
  endtask

  task automatic test_bad_header(input logic [31:0] n);
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL hdr_error n=%0d: got %0b want 1", n, error); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL hdr_ready n=%0d: got %0b want 0", n, rx_ready); end
    rx_data = 8'h13;
    rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    total++; if (we_cnt !== 0) begin bad++; $display("FAIL hdr_we n=%0d: got %0d want 0", n, we_cnt); end
    total++; if (acc_cnt !== 4) begin bad++; $display("FAIL hdr_acc n=%0d: got %0d want 4", n, acc_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_stream(13, 8'h92, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total++; if (acc_cnt !== 13) begin bad++; $display("FAIL b2b_accepts: got %0d want 13", acc_cnt); end
    total++; if (ready_in_write !== 0) begin bad++; $display("FAIL b2b_ready_in_write: got %0d want 0", ready_in_write); end
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL b2b_we_count: got %0d want 2", we_cnt); end
    if (wd_q.size() >= 2) begin
      total++; if (wd_q[0] !== 32'h00000013) begin bad++; $display("FAIL b2b_data0: got %h want 00000013", wd_q[0]); end
      total++; if (wd_q[1] !== 32'h00100093) begin bad++; $display("FAIL b2b_data1: got %h want 00100093", wd_q[1]); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %0b want 1", done); end
  endtask

  task automatic test_timeout();
    int ready_hi;
    do_reset();
    send_stream(6, 8'h92, 0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k == 16) begin
        total++; if (error !== 1'b0) begin bad++; $display("FAIL tmo_early: got %0b want 0 at 16", error); end
      end
    end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL tmo_error: got %0b want 1 at 17", error); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL tmo_core_rst: got %0b want 1", core_rst); end
    ready_hi = 0;
    rx_data = 8'h00;
    rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) ready_hi++;
    end
    rx_valid = 1'b0;
    total++; if (ready_hi !== 0) begin bad++; $display("FAIL tmo_ready: got %0d high cycles want 0", ready_hi); end
    total++; if (acc_cnt !== 6) begin bad++; $display("FAIL tmo_accepts: got %0d want 6", acc_cnt); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_stream(7, 8'h92, 0, 1'b0);
    rst = 1'b1;
    #1;
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %0b want 0", rx_ready); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL mid_core_rst: got %0b want 1", core_rst); end
    total++; if (error !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_flags: got error=%0b done=%0b want 0 0", error, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    send_stream(13, 8'h92, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (we_cnt !== 2) begin bad++; $display("FAIL mid_we_count: got %0d want 2", we_cnt); end
    if (wa_q.size() >= 2) begin
      total++; if (wa_q[0] !== 32'h0) begin bad++; $display("FAIL mid_addr0: got %h want 0", wa_q[0]); end
      total++; if (wd_q[0] !== 32'h00000013) begin bad++; $display("FAIL mid_data0: got %h want 00000013", wd_q[0]); end
      total++; if (wa_q[1] !== 32'h4) begin bad++; $display("FAIL mid_addr1: got %h want 4", wa_q[1]); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_done: got %0b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_bad_header(32'd0);
    test_bad_header(32'd1025);
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width; MAX_WORDS = 2**ADDR_W.
REQ-002 Parameter TIMEOUT_CYC, default 1000000, maximum idle cycles between accepted bytes once a load has started.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx_data  input  8  byte from the serial receiver.
REQ-006 rx_valid  input  1  rx_data valid; held with rx_data stable until accepted.
REQ-007 rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready.
REQ-008 imem_we  output  1  one-cycle write strobe to instruction RAM.
REQ-009 imem_addr  output  32  byte address of the write, word-aligned (bits [1:0] = 0).
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 core_rst  output  1  held-in-reset request to the CPU core; high until a load completes successfully.
REQ-012 done  output  1  sticky: load completed and checksum matched.
REQ-013 error  output  1  sticky: load aborted (bad count, bad checksum, timeout).

Function
REQ-014 The frame format SHALL be: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian), then 1 checksum byte.
REQ-015 The checksum SHALL be the XOR of all header and payload bytes; the checksum byte itself is excluded.
REQ-016 The FSM states SHALL be: IDLE, HDR, DATA, WRITE, CSUM, DONE and ERR.
REQ-017 IDLE SHALL go to HDR unconditionally on the first clock after rst deasserts.
REQ-018 HDR SHALL collect 4 bytes; after the 4th, the next state is ERR if N == 0 or N > MAX_WORDS, otherwise DATA.
REQ-019 DATA SHALL collect 4 bytes per word; a word's 4th byte accepted in cycle t SHALL enter WRITE at t+1.
REQ-020 In WRITE, imem_we = 1 for exactly that cycle, with imem_addr = word_idx*4 and imem_wdata = the assembled word; word_idx then increments.
REQ-021 WRITE SHALL return to DATA at t+2, or go to CSUM if word_idx has reached N.
REQ-022 In CSUM, the accepted byte is compared with the running XOR: match -> DONE, mismatch -> ERR, entered the cycle after acceptance.
REQ-023 rx_ready SHALL be registered and equal 1 only in HDR, DATA and CSUM; bytes offered in any other state remain pending and are not consumed.
REQ-024 DONE and ERR SHALL be terminal until rst: rx_ready = 0 and imem_we = 0; done = 1 in DONE, error = 1 in ERR.
REQ-025 core_rst SHALL be 0 only in DONE; ERR keeps the core held in reset.
REQ-026 The idle counter SHALL clear on every accepted byte and count only in HDR (after the first byte), DATA and CSUM.
REQ-027 When the idle counter reaches TIMEOUT_CYC, the FSM SHALL enter ERR on the next cycle.
REQ-028 word_idx SHALL be ADDR_W+1 bits wide, and imem_addr SHALL be word_idx zero-extended and shifted left by 2, so it never wraps.
REQ-029 Writes already performed SHALL NOT be undone on ERR.

Reset
REQ-030 While rst = 1: state = IDLE, rx_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst = 1, done = 0, error = 0, and all counters and checksum = 0.
REQ-031 Reset asserted mid-load SHALL abort immediately; the next load restarts at HDR and address 0.

Structure
REQ-032 Package prog_loader_pkg SHALL hold the state enumeration, the header length (4) and the bytes-per-word constant (4).
REQ-033 One sub-module, byte_to_word, SHALL hold the little-endian shift register and byte counter, with a clear input and a word_full output.

Verification
REQ-034 Stream 02 00 00 00 13 00 00 00 93 00 10 00 92 -> writes (0x0, 0x00000013) and (0x4, 0x00100093), then done = 1 and core_rst = 0.
REQ-035 Same stream with checksum 00 -> both writes occur, then error = 1 and core_rst stays 1.
REQ-036 Header 00 00 00 00 -> error = 1 after the 4th byte with no imem_we; header 01 04 00 00 (N = 1025, ADDR_W = 10) -> same result.
REQ-037 rx_valid held high continuously -> rx_ready = 0 in each WRITE cycle, and no byte is lost or duplicated (verify against the REQ-034 data).
REQ-038 TIMEOUT_CYC = 16, stop after 6 bytes -> error = 1 exactly 17 cycles after the last acceptance; rx_ready = 0 thereafter.
REQ-039 rst pulse after the 7th byte, then the full REQ-034 stream -> outputs return to reset values, then a correct load from address 0.
